tri_scan_sequencer: RTL and testbench

Rasterization controller for the in-triangle pixel checker. It accepts one triangle per handshake and computes its screen-clamped bounding box. It then scans that box in raster order, issuing one point test per cycle to the checker. Coordinates are tracked in an in-order FIFO, and only the pixels reported inside are emitted as a backpressured fragment stream toward the framebuffer writer.

---
 rtl/tri_scan_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tri_scan_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_scan_sequencer.sv
// Triangle rasterization controller: computes a screen-clamped bounding box, scans it
// in raster order against the point checker and streams out the inside pixels.
module tri_scan_sequencer #(
    parameter int SYS_BIT_WIDTH = 10,
    parameter int SCREEN_W      = 320,
    parameter int SCREEN_H      = 180,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic                       tri_valid_in,
    output logic                       tri_ready_out,
    input  logic [6*SYS_BIT_WIDTH-1:0] tri_vertices_in,
    output logic [6*SYS_BIT_WIDTH-1:0] check_vertices_out,
    output logic                       check_valid_out,
    output logic [SYS_BIT_WIDTH-1:0]   check_x_out,
    output logic [SYS_BIT_WIDTH-1:0]   check_y_out,
    input  logic                       check_valid_in,
    input  logic                       check_inside_in,
    output logic                       frag_valid_out,
    input  logic                       frag_ready_in,
    output logic [SYS_BIT_WIDTH-1:0]   frag_x_out,
    output logic [SYS_BIT_WIDTH-1:0]   frag_y_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [2*SYS_BIT_WIDTH-1:0] frag_count_out
);
    localparam int W  = SYS_BIT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BBOX  = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [W-1:0]  X_LAST = W'(SCREEN_W - 1);
    localparam logic [W-1:0]  Y_LAST = W'(SCREEN_H - 1);
    localparam logic [AW:0]   FULL_OCC = (AW+1)'(FIFO_DEPTH);

    logic [1:0]     state;
    logic [6*W-1:0] vert_q;
    logic [W-1:0]   x, y, min_x_q, max_x_q, max_y_q;
    logic [AW:0]    wr_ptr, res_ptr, rd_ptr;
    logic [2*W-1:0] frag_count;
    logic           done_q;

    logic [W-1:0] fifo_x  [FIFO_DEPTH];
    logic [W-1:0] fifo_y  [FIFO_DEPTH];
    logic         fifo_in [FIFO_DEPTH];

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic [W-1:0] ax, ay, bx, by, cx, cy;
    logic [W-1:0] bb_min_x, bb_min_y, bb_max_x, bb_max_y;
    logic         bb_off;

    always_comb begin
        ax = vert_q[6*W-1 -: W];
        ay = vert_q[5*W-1 -: W];
        bx = vert_q[4*W-1 -: W];
        by = vert_q[3*W-1 -: W];
        cx = vert_q[2*W-1 -: W];
        cy = vert_q[W-1 -: W];
        bb_min_x = min3(ax, bx, cx);
        bb_min_y = min3(ay, by, cy);
        bb_max_x = max3(ax, bx, cx);
        bb_max_y = max3(ay, by, cy);
        if (bb_max_x > X_LAST) bb_max_x = X_LAST;
        if (bb_max_y > Y_LAST) bb_max_y = Y_LAST;
        bb_off = (bb_min_x > X_LAST) || (bb_min_y > Y_LAST);
    end

    logic [AW:0] occupancy;
    logic        issue, res_wr, head_resolved, head_inside, pop, frag_fire, accept;

    always_comb begin
        occupancy     = wr_ptr - rd_ptr;
        accept        = (state == S_IDLE) && tri_valid_in;
        issue         = (state == S_SCAN) && (occupancy != FULL_OCC);
        res_wr        = check_valid_in && (res_ptr != wr_ptr);
        head_resolved = (rd_ptr != res_ptr);
        head_inside   = fifo_in[rd_ptr[AW-1:0]];
        frag_fire     = head_resolved && head_inside && frag_ready_in;
        // Outside heads retire on their own; inside heads wait for the consumer.
        pop           = head_resolved && (!head_inside || frag_ready_in);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vert_q     <= '0;
            x          <= '0;
            y          <= '0;
            min_x_q    <= '0;
            max_x_q    <= '0;
            max_y_q    <= '0;
            wr_ptr     <= '0;
            res_ptr    <= '0;
            rd_ptr     <= '0;
            frag_count <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == S_DRAIN) && (occupancy == '0);
            case (state)
                S_IDLE: if (tri_valid_in) begin
                    vert_q <= tri_vertices_in;
                    state  <= S_BBOX;
                end
                S_BBOX: begin
                    min_x_q <= bb_min_x;
                    max_x_q <= bb_max_x;
                    max_y_q <= bb_max_y;
                    x       <= bb_min_x;
                    y       <= bb_min_y;
                    state   <= bb_off ? S_DRAIN : S_SCAN;
                end
                S_SCAN: if (issue) begin
                    if (x == max_x_q) begin
                        x <= min_x_q;
                        y <= y + 1'b1;
                        if (y == max_y_q) state <= S_DRAIN;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: if (occupancy == '0) state <= S_IDLE;
            endcase
            if (issue)  wr_ptr  <= wr_ptr + 1'b1;
            if (res_wr) res_ptr <= res_ptr + 1'b1;
            if (pop)    rd_ptr  <= rd_ptr + 1'b1;
            if (accept)         frag_count <= '0;
            else if (frag_fire) frag_count <= frag_count + 1'b1;
        end
    end

    // Entry storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk_in) begin
        if (issue) begin
            fifo_x[wr_ptr[AW-1:0]] <= x;
            fifo_y[wr_ptr[AW-1:0]] <= y;
        end
        if (res_wr) fifo_in[res_ptr[AW-1:0]] <= check_inside_in;
    end

    assign tri_ready_out      = (state == S_IDLE);
    assign busy_out           = (state != S_IDLE);
    assign done_out           = done_q;
    assign check_vertices_out = vert_q;
    assign check_valid_out    = issue;
    assign check_x_out        = x;
    assign check_y_out        = y;
    assign frag_valid_out     = head_resolved && head_inside;
    assign frag_x_out         = fifo_x[rd_ptr[AW-1:0]];
    assign frag_y_out         = fifo_y[rd_ptr[AW-1:0]];
    assign frag_count_out     = frag_count;
endmodule

// File: tb/tb_tri_scan_sequencer.sv
// Directed testbench for tri_scan_sequencer with a fixed-latency (4) checker model.
module tb_tri_scan_sequencer;
    localparam int W = 10;

    logic           clk_in = 1'b0;
    logic           rst_n = 1'b0;
    logic           tri_valid_in = 1'b0;
    logic           tri_ready_out;
    logic [6*W-1:0] tri_vertices_in = '0;
    logic [6*W-1:0] check_vertices_out;
    logic           check_valid_out;
    logic [W-1:0]   check_x_out, check_y_out;
    logic           check_valid_in;
    logic           check_inside_in;
    logic           frag_valid_out;
    logic           frag_ready_in = 1'b1;
    logic [W-1:0]   frag_x_out, frag_y_out;
    logic           busy_out, done_out;
    logic [2*W-1:0] frag_count_out;

    always #5 clk_in = ~clk_in;

    tri_scan_sequencer #(
        .SYS_BIT_WIDTH(W), .SCREEN_W(320), .SCREEN_H(180), .FIFO_DEPTH(16)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .tri_vertices_in(tri_vertices_in), .check_vertices_out(check_vertices_out),
        .check_valid_out(check_valid_out), .check_x_out(check_x_out), .check_y_out(check_y_out),
        .check_valid_in(check_valid_in), .check_inside_in(check_inside_in),
        .frag_valid_out(frag_valid_out), .frag_ready_in(frag_ready_in),
        .frag_x_out(frag_x_out), .frag_y_out(frag_y_out),
        .busy_out(busy_out), .done_out(done_out), .frag_count_out(frag_count_out)
    );

    // Checker model: 4-cycle pipeline, not tied to the sequencer's reset.
    int inside_mode = 0;
    logic [2*W:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;

    function automatic logic model_inside(input logic [W-1:0] px, input logic [W-1:0] py);
        case (inside_mode)
            0:       return (int'(px) + int'(py)) <= 3;
            1:       return 1'b1;
            default: return ((int'(px) + int'(py)) % 2) == 0;
        endcase
    endfunction

    always @(posedge clk_in) begin
        p0 <= {check_valid_out, check_x_out, check_y_out};
        p1 <= p0;
        p2 <= p1;
        p3 <= p2;
    end
    assign check_valid_in  = p3[2*W];
    assign check_inside_in = model_inside(p3[2*W-1:W], p3[W-1:0]);

    int cyc = 0, acc_cyc = 0, first_iss_cyc = 0, last_iss_cyc = 0, done_cyc = 0;
    int n_done = 0, done_base = 0;
    logic [W-1:0] iss_x[$], iss_y[$], frg_x[$], frg_y[$], ex_x[$], ex_y[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (tri_valid_in && tri_ready_out) acc_cyc = cyc;
            if (check_valid_out) begin
                if (iss_x.size() == 0) first_iss_cyc = cyc;
                last_iss_cyc = cyc;
                iss_x.push_back(check_x_out);
                iss_y.push_back(check_y_out);
            end
            if (frag_valid_out && frag_ready_in) begin
                frg_x.push_back(frag_x_out);
                frg_y.push_back(frag_y_out);
            end
            if (done_out) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        iss_x.delete(); iss_y.delete(); frg_x.delete(); frg_y.delete();
        done_base = n_done;
    endtask

    task automatic submit(input int ax, ay, bx, by, cx, cy);
        clear_logs();
        @(posedge clk_in); #1;
        tri_vertices_in = {W'(ax), W'(ay), W'(bx), W'(by), W'(cx), W'(cy)};
        tri_valid_in = 1'b1;
        @(posedge clk_in); #1;
        tri_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (n_done != done_base) break;
        end
        repeat (3) @(negedge clk_in);
        check({tag, "_done_pulses"}, n_done - done_base, 1);
    endtask

    task automatic build_exp(input int x0, x1, y0, y1);
        ex_x.delete(); ex_y.delete();
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                if (model_inside(W'(xx), W'(yy))) begin
                    ex_x.push_back(W'(xx));
                    ex_y.push_back(W'(yy));
                end
    endtask

    task automatic check_raster(input string tag, input int x0, x1, y0, y1);
        int mism = 0, idx = 0;
        check({tag, "_issues"}, iss_x.size(), (x1 - x0 + 1) * (y1 - y0 + 1));
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++) begin
                if (idx < iss_x.size())
                    if (int'(iss_x[idx]) != xx || int'(iss_y[idx]) != yy) mism++;
                idx++;
            end
        check({tag, "_issue_order"}, mism, 0);
    endtask

    task automatic check_frags(input string tag);
        int mism = 0;
        check({tag, "_frags"}, frg_x.size(), ex_x.size());
        for (int i = 0; i < frg_x.size() && i < ex_x.size(); i++)
            if (frg_x[i] != ex_x[i] || frg_y[i] != ex_y[i]) mism++;
        check({tag, "_frag_order"}, mism, 0);
    endtask

    initial begin
        int oob;
        // Reset values
        #3;
        check("rst_ready", tri_ready_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_cvalid", check_valid_out, 0);
        check("rst_fvalid", frag_valid_out, 0);
        check("rst_done", done_out, 0);
        check("rst_count", frag_count_out, 0);
        check("rst_xy", {check_x_out, check_y_out}, 0);
        check("rst_vert", check_vertices_out, 0);
        @(posedge clk_in); #1;
        rst_n = 1'b1;

        // Small triangle, free-flowing output
        inside_mode = 0;
        frag_ready_in = 1'b1;
        submit(0, 0, 3, 0, 0, 3);
        wait_done("t1", 200);
        check_raster("t1", 0, 3, 0, 3);
        check("t1_first_issue_lat", first_iss_cyc - acc_cyc, 2);
        check("t1_last_issue_lat", last_iss_cyc - acc_cyc, 17);
        build_exp(0, 3, 0, 3);
        check_frags("t1");
        check("t1_count", frag_count_out, 10);
        check("t1_vert", check_vertices_out, {W'(0), W'(0), W'(3), W'(0), W'(0), W'(3)});
        check("t1_idle", tri_ready_out, 1);

        // Same triangle with the consumer stalled for 40 cycles
        frag_ready_in = 1'b0;
        submit(0, 0, 3, 0, 0, 3);
        repeat (40) @(posedge clk_in);
        @(negedge clk_in);
        check("t2_stall_issues", iss_x.size(), 16);
        check("t2_stall_frags", frg_x.size(), 0);
        check("t2_stall_fvalid", frag_valid_out, 1);
        check("t2_stall_head", {frag_x_out, frag_y_out}, 0);
        check("t2_stall_busy", busy_out, 1);
        @(posedge clk_in); #1;
        frag_ready_in = 1'b1;
        wait_done("t2", 200);
        check_frags("t2");
        check("t2_count", frag_count_out, 10);

        // Bounding box clamped at the screen corner
        inside_mode = 2;
        submit(300, 170, 400, 170, 300, 250);
        wait_done("t3", 600);
        check_raster("t3", 300, 319, 170, 179);
        oob = 0;
        for (int i = 0; i < iss_x.size(); i++)
            if (iss_x[i] > 10'd319 || iss_y[i] > 10'd179) oob++;
        check("t3_out_of_screen", oob, 0);
        build_exp(300, 319, 170, 179);
        check_frags("t3");
        check("t3_count", frag_count_out, 100);

        // Fully off-screen triangle
        submit(320, 10, 500, 20, 330, 40);
        wait_done("t4", 50);
        check("t4_issues", iss_x.size(), 0);
        check("t4_done_lat", done_cyc - acc_cyc, 3);
        check("t4_count", frag_count_out, 0);

        // Reset pulse mid-scan with results in flight
        inside_mode = 0;
        submit(0, 0, 3, 0, 0, 3);
        for (int i = 0; i < 50 && iss_x.size() < 6; i++) @(negedge clk_in);
        check("t5_pre_issues", iss_x.size() >= 6, 1);
        @(posedge clk_in); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", tri_ready_out, 1);
        check("t5_rst_busy", busy_out, 0);
        check("t5_rst_cvalid", check_valid_out, 0);
        check("t5_rst_fvalid", frag_valid_out, 0);
        check("t5_rst_count", frag_count_out, 0);
        clear_logs();
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk_in);
        check("t5_stale_frags", frg_x.size(), 0);
        check("t5_stale_issues", iss_x.size(), 0);
        check("t5_no_done", n_done - done_base, 0);
        check("t5_fvalid", frag_valid_out, 0);

        // Degenerate single-point triangle after the abort
        inside_mode = 1;
        submit(5, 5, 5, 5, 5, 5);
        wait_done("t6", 50);
        check("t6_issues", iss_x.size(), 1);
        check("t6_issue_xy", iss_x.size() == 1 ? {iss_x[0], iss_y[0]} : 20'hfffff, {10'd5, 10'd5});
        check("t6_frags", frg_x.size(), 1);
        check("t6_frag_xy", frg_x.size() == 1 ? {frg_x[0], frg_y[0]} : 20'hfffff, {10'd5, 10'd5});
        check("t6_count", frag_count_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
